// File: rtl/count_run_if.sv
// count_run_if: signal bundle between the run controller and the board/datapath side.
// master = controller, slave = keys, switches and the BCD digit datapath.
//
// Strobe semantics: tick and clr are single-cycle pulses with no back-pressure.
// The datapath must act on every cycle in which a strobe is high and ignore it otherwise.
// dir, run, done and state are levels that are valid every cycle.
interface count_run_if;
  // raw buttons and level switches
  logic       key_start;
  logic       key_stop;
  logic       key_clr;
  logic       sw_dir;
  logic       sw_fast;
  // datapath status
  logic       digits_zero;
  logic       digits_max;
  // controller outputs
  logic       tick;
  logic       dir;
  logic       clr;
  logic       run;
  logic       done;
  logic [1:0] state;

  modport master (
    input  key_start,
    input  key_stop,
    input  key_clr,
    input  sw_dir,
    input  sw_fast,
    input  digits_zero,
    input  digits_max,
    output tick,
    output dir,
    output clr,
    output run,
    output done,
    output state
  );

  modport slave (
    output key_start,
    output key_stop,
    output key_clr,
    output sw_dir,
    output sw_fast,
    output digits_zero,
    output digits_max,
    input  tick,
    input  dir,
    input  clr,
    input  run,
    input  done,
    input  state
  );
endinterface

// File: rtl/count_run_ctrl.sv
// count_run_ctrl: run/sequence controller for the 4-digit BCD counter.
// Debounces the start/stop/clear buttons, runs the IDLE/RUN/PAUSE/DONE machine,
// owns the tick prescaler and emits tick/dir/clr towards the digit datapath.
// Optional feature macro: COUNT_AUTORELOAD_EN
//   defined   -> a terminal wrap in RUN clears the digits and keeps running
//   undefined -> a terminal wrap in RUN stops in DONE
module count_run_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  count_run_if.master bus
);

  // prescaler wide enough to hold CLK_HZ-1 with headroom
  localparam int PW = $clog2(CLK_HZ) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [PW-1:0] LIM_NORM = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] LIM_FAST = PW'(CLK_HZ / 2 - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);

  // key bit positions inside the 3-bit key vectors
  localparam int K_START = 0;
  localparam int K_STOP  = 1;
  localparam int K_CLR   = 2;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  // key conditioning
  logic [2:0]    key_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    level;
  logic [2:0]    key_ev;
  logic [DW-1:0] db_cnt [3];

  logic ev_start;
  logic ev_stop;
  logic ev_clr;

  // controller state
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q,   dir_d;
  logic          tick_q,  tick_d;
  logic          clr_q,   clr_d;

  logic [PW-1:0] lim_m1;
  logic          wrap;
  logic          terminal;

  assign key_raw = {bus.key_clr, bus.key_stop, bus.key_start};

  assign ev_start = key_ev[K_START];
  assign ev_stop  = key_ev[K_STOP];
  assign ev_clr   = key_ev[K_CLR];

  // Synchronise each raw key, accept a new level after DEBOUNCE_CYC equal samples,
  // and raise a one-cycle event on every accepted press (release is silent).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      level  <= '0;
      key_ev <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1  <= key_raw;
      sync2  <= sync1;
      key_ev <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= sync2[i];
          key_ev[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Tick period follows sw_fast live; >= lets a shortened period wrap at once.
  assign lim_m1   = bus.sw_fast ? LIM_FAST : LIM_NORM;
  assign wrap     = (presc_q >= lim_m1);
  assign terminal = (~dir_q & bus.digits_max) | (dir_q & bus.digits_zero);

  // Next-state logic: clear beats stop beats start, strobes default low.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    clr_d   = 1'b0;
    if (ev_clr) begin
      clr_d   = 1'b1;
      presc_d = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // direction is captured only when a run begins
          if (ev_start) begin
            dir_d   = bus.sw_dir;
            presc_d = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (ev_stop) begin
            state_d = S_PAUSE;
          end else if (wrap) begin
            presc_d = '0;
            if (terminal) begin
`ifdef COUNT_AUTORELOAD_EN
              clr_d = 1'b1;
`else
              state_d = S_DONE;
`endif
            end else begin
              tick_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSE: begin
          // prescaler holds so the interrupted period resumes where it left off
          if (ev_start) begin
            state_d = S_RUN;
          end
        end
        default: begin
          // DONE: only a clear event leaves
        end
      endcase
    end
  end

  // Controller registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
    end
  end

  assign bus.tick  = tick_q;
  assign bus.clr   = clr_q;
  assign bus.dir   = dir_q;
  assign bus.state = state_q;
  assign bus.run   = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);

endmodule

// File: tb/tb_count_run_ctrl.sv
// tb_count_run_ctrl: directed bench for count_run_ctrl with CLK_HZ=20, DEBOUNCE_CYC=4.
// A key set at the falling edge where cyc==c is seen as a state change at cyc==c+7.
module tb_count_run_ctrl;

  localparam int CLK_HZ = 20;
  localparam int DB_CYC = 4;

  logic clk = 1'b0;
  logic rst;

  count_run_if bus ();

  count_run_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_CYC(DB_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tick_cnt = 0;
  always @(negedge clk) if (bus.tick) tick_cnt++;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_keys(input logic [2:0] k);
    bus.key_clr   = k[2];
    bus.key_stop  = k[1];
    bus.key_start = k[0];
  endtask

  task automatic go_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_tick(output int c);
    c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tick) begin
        c = cyc;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int c0;
  int s;
  int t, t2, t3, t4;
  int n;

  initial begin
    set_keys(3'b000);
    bus.sw_dir      = 1'b0;
    bus.sw_fast     = 1'b0;
    bus.digits_zero = 1'b0;
    bus.digits_max  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_state", bus.state, 0);
    check("rst_tick",  bus.tick,  0);
    check("rst_clr",   bus.clr,   0);
    check("rst_dir",   bus.dir,   0);
    check("rst_run",   bus.run,   0);
    check("rst_done",  bus.done,  0);

    // 3-cycle glitch on start is rejected
    c0 = cyc;
    set_keys(3'b001);
    go_to(c0 + 3);
    set_keys(3'b000);
    go_to(c0 + 15);
    check("glitch_idle", bus.state, 0);

    // clean start press: RUN exactly 7 cycles after the raw edge
    c0 = cyc;
    set_keys(3'b001);
    go_to(c0 + 6);
    check("start_lat_m1", bus.state, 0);
    go_to(c0 + 7);
    check("start_lat", bus.state, 1);
    check("start_run", bus.run, 1);
    check("start_dir", bus.dir, 0);
    s = c0 + 7;
    go_to(c0 + 10);
    set_keys(3'b000);

    // normal period: 20 cycles
    wait_tick(t);
    check("tick_first", t, s + 20);
    @(negedge clk);
    check("tick_width", bus.tick, 0);
    wait_tick(t2);
    check("tick_period_norm", t2 - t, 20);

    // fast period: 10 cycles
    bus.sw_fast = 1'b1;
    wait_tick(t3);
    check("tick_period_fast1", t3 - t2, 10);
    wait_tick(t4);
    check("tick_period_fast2", t4 - t3, 10);

    // stop with prescaler at 7, back to normal period
    bus.sw_fast = 1'b0;
    @(negedge clk);
    c0 = cyc;
    set_keys(3'b010);
    go_to(c0 + 6);
    check("stop_lat_m1", bus.state, 1);
    go_to(c0 + 7);
    check("stop_pause", bus.state, 2);
    go_to(c0 + 10);
    set_keys(3'b000);
    n = tick_cnt;
    go_to(c0 + 40);
    check("pause_no_tick", tick_cnt, n);

    // resume: remaining 13 cycles of the interrupted period
    c0 = cyc;
    set_keys(3'b001);
    go_to(c0 + 7);
    check("resume_run", bus.state, 1);
    go_to(c0 + 10);
    set_keys(3'b000);
    wait_tick(t);
    check("resume_tick", t - (c0 + 7), 13);

    // stop and start together in RUN -> PAUSE
    c0 = cyc;
    set_keys(3'b011);
    go_to(c0 + 7);
    check("stopstart_pause", bus.state, 2);
    go_to(c0 + 10);
    set_keys(3'b000);
    go_to(c0 + 20);

    // clear and start together in PAUSE -> IDLE with clear pulse
    c0 = cyc;
    set_keys(3'b101);
    go_to(c0 + 7);
    check("clrstart_state", bus.state, 0);
    check("clrstart_clr", bus.clr, 1);
    go_to(c0 + 8);
    check("clrstart_clr_w", bus.clr, 0);
    check("clrstart_idle", bus.state, 0);
    go_to(c0 + 10);
    set_keys(3'b000);
    go_to(c0 + 20);

`ifndef COUNT_AUTORELOAD_EN
    // count down into zero -> DONE without tick
    bus.sw_dir      = 1'b1;
    bus.digits_zero = 1'b1;
    c0 = cyc;
    set_keys(3'b001);
    go_to(c0 + 7);
    check("down_run", bus.state, 1);
    check("down_dir", bus.dir, 1);
    go_to(c0 + 10);
    set_keys(3'b000);
    n = tick_cnt;
    go_to(c0 + 26);
    check("term_pre", bus.state, 1);
    go_to(c0 + 27);
    check("term_done_state", bus.state, 3);
    check("term_done", bus.done, 1);
    check("term_tick", bus.tick, 0);
    check("term_tick_cnt", tick_cnt, n);

    // start ignored in DONE, dir stays latched
    bus.sw_dir = 1'b0;
    c0 = cyc;
    set_keys(3'b001);
    go_to(c0 + 10);
    check("done_start_ign", bus.state, 3);
    set_keys(3'b000);
    go_to(c0 + 20);
    check("dir_held", bus.dir, 1);

    // clear leaves DONE
    c0 = cyc;
    set_keys(3'b100);
    go_to(c0 + 7);
    check("done_clr", bus.clr, 1);
    check("done_clr_state", bus.state, 0);
    check("done_clr_done", bus.done, 0);
    go_to(c0 + 8);
    check("done_clr_w", bus.clr, 0);
    go_to(c0 + 10);
    set_keys(3'b000);
    go_to(c0 + 20);
`else
    // count up into 9999 -> clear pulse, keep running
    bus.sw_dir     = 1'b0;
    bus.digits_max = 1'b1;
    c0 = cyc;
    set_keys(3'b001);
    go_to(c0 + 7);
    check("ar_run", bus.state, 1);
    go_to(c0 + 10);
    set_keys(3'b000);
    n = tick_cnt;
    go_to(c0 + 26);
    check("ar_clr_pre", bus.clr, 0);
    go_to(c0 + 27);
    check("ar_clr", bus.clr, 1);
    check("ar_tick", bus.tick, 0);
    check("ar_state", bus.state, 1);
    check("ar_done", bus.done, 0);
    go_to(c0 + 47);
    check("ar_clr2", bus.clr, 1);
    check("ar_tick_cnt", tick_cnt, n);
    bus.digits_max = 1'b0;
    c0 = cyc;
    set_keys(3'b100);
    go_to(c0 + 7);
    check("ar_clr_idle", bus.state, 0);
    go_to(c0 + 10);
    set_keys(3'b000);
    go_to(c0 + 20);
`endif
    bus.digits_zero = 1'b0;
    bus.digits_max  = 1'b0;

    // asynchronous reset in the middle of a run
    bus.sw_dir = 1'b1;
    c0 = cyc;
    set_keys(3'b001);
    go_to(c0 + 7);
    check("mid_run", bus.state, 1);
    check("mid_dir", bus.dir, 1);
    go_to(c0 + 10);
    set_keys(3'b000);
    go_to(c0 + 12);
    #2 rst = 1'b1;
    #1;
    check("arst_state", bus.state, 0);
    check("arst_tick",  bus.tick,  0);
    check("arst_clr",   bus.clr,   0);
    check("arst_dir",   bus.dir,   0);
    check("arst_done",  bus.done,  0);
    check("arst_run",   bus.run,   0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_after", bus.state, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
